// File: rtl/rect_fill_writer.sv
// Rectangle draw engine for the 96x64 OLED framebuffer: clips one command to the
// screen and streams a write per covered pixel, either solid or 1-pixel outline.
module rect_fill_writer #(
    parameter int SCR_W  = 96,
    parameter int SCR_H  = 64,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [6:0]        cmd_x0,
    input  logic [6:0]        cmd_y0,
    input  logic [6:0]        cmd_w,
    input  logic [6:0]        cmd_h,
    input  logic [15:0]       cmd_color,
    input  logic              cmd_outline,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_WRITE, S_DONE} state_t;

    state_t state_q, state_d;

    logic [6:0]        x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [15:0]       color_q, color_d;
    logic              outline_q, outline_d;
    logic [6:0]        xe_q, xe_d, ye_q, ye_d;
    logic [6:0]        x_q, x_d, y_q, y_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic [7:0] x_sum, y_sum;
    logic [6:0] xe_clip, ye_clip;
    logic       clip_empty;
    logic       last_col, last_row, edge_row;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [6:0] y, input logic [6:0] x);
        pix_addr = ADDR_W'(y) * ADDR_W'(SCR_W) + ADDR_W'(x);
    endfunction

    // 8-bit sums so x0+w cannot wrap before being clamped to the screen edge.
    always_comb begin
        x_sum      = {1'b0, x0_q} + {1'b0, w_q};
        y_sum      = {1'b0, y0_q} + {1'b0, h_q};
        xe_clip    = (x_sum > 8'(SCR_W)) ? 7'(SCR_W) : x_sum[6:0];
        ye_clip    = (y_sum > 8'(SCR_H)) ? 7'(SCR_H) : y_sum[6:0];
        clip_empty = (x0_q >= 7'(SCR_W)) || (y0_q >= 7'(SCR_H)) ||
                     (w_q == 7'd0) || (h_q == 7'd0);
    end

    always_comb begin
        last_col = (x_q == xe_q - 7'd1);
        last_row = (y_q == ye_q - 7'd1);
        edge_row = (y_q == y0_q) || last_row;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_CLIP;
            S_CLIP:  state_d = clip_empty ? S_DONE : S_WRITE;
            S_WRITE: if (wr_ready && last_col && last_row) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
    end

    always_comb begin
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        color_d   = color_q;
        outline_d = outline_q;
        xe_d      = xe_q;
        ye_d      = ye_q;
        x_d       = x_q;
        y_d       = y_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x0_d      = cmd_x0;
                    y0_d      = cmd_y0;
                    w_d       = cmd_w;
                    h_d       = cmd_h;
                    color_d   = cmd_color;
                    outline_d = cmd_outline;
                end
            end
            S_CLIP: begin
                xe_d = xe_clip;
                ye_d = ye_clip;
                x_d  = x0_q;
                y_d  = y0_q;
                if (!clip_empty) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_addr(y0_q, x0_q);
                    wr_data_d = color_q;
                end
            end
            S_WRITE: begin
                if (wr_ready) begin
                    if (last_col) begin
                        if (last_row) begin
                            wr_en_d = 1'b0;
                        end else begin
                            x_d = x0_q;
                            y_d = y_q + 7'd1;
                        end
                    end else if (outline_q && !edge_row && (x_q == x0_q)) begin
                        // Interior outline rows only touch the left and right edge columns.
                        x_d = xe_q - 7'd1;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                    wr_addr_d = pix_addr(y_d, x_d);
                end
            end
            default: wr_en_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            outline_q <= 1'b0;
            xe_q      <= '0;
            ye_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            color_q   <= color_d;
            outline_q <= outline_d;
            xe_q      <= xe_d;
            ye_q      <= ye_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Bench for rect_fill_writer: directed and random rectangle commands compared
// against a loop-based pixel-list model, with stall, busy and reset scenarios.
module tb_rect_fill_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [15:0] cmd_color;
    logic        cmd_outline;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    rect_fill_writer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .cmd_outline(cmd_outline),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Expected write list: every clipped pixel in row-major order, dropping interior
    // pixels of outline commands.
    task automatic build_model(input int x0, input int y0, input int w, input int h, input bit outl);
        int xe, ye;
        exp_q.delete();
        xe = (x0 + w < 96) ? x0 + w : 96;
        ye = (y0 + h < 64) ? y0 + h : 64;
        for (int yy = y0; yy < ye; yy++)
            for (int xx = x0; xx < xe; xx++)
                if (!outl || yy == y0 || yy == ye - 1 || xx == x0 || xx == xe - 1)
                    exp_q.push_back(yy * 96 + xx);
    endtask

    // mode 0: wr_ready always 1; mode 1: 1,0,0 repeating; mode 2: random.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [15:0] col, input bit outl, input int mode, input bit poke);
        int n, idx, first_cyc, last_hs, done_cyc, budget;
        bit prev_stall;
        logic [12:0] prev_addr;
        logic [15:0] prev_data;
        build_model(x0, y0, w, h, outl);
        n = exp_q.size();
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid   = 1'b1;
        cmd_x0      = 7'(x0);
        cmd_y0      = 7'(y0);
        cmd_w       = 7'(w);
        cmd_h       = 7'(h);
        cmd_color   = col;
        cmd_outline = outl;
        wr_ready    = 1'b0;
        first_cyc = -1; last_hs = -1; done_cyc = -1; idx = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        budget = n * 10 + 20;
        for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
            @(negedge clk);
            cmd_valid = poke && (cyc == 3);
            if (cmd_valid) begin
                cmd_x0      = 7'($urandom);
                cmd_y0      = 7'($urandom);
                cmd_w       = 7'($urandom);
                cmd_h       = 7'($urandom);
                cmd_color   = 16'($urandom);
                cmd_outline = 1'($urandom);
            end
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (cyc >= 2) && ((cyc - 2) % 3 == 0);
                default: wr_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (prev_stall) begin
                check("hold_en", 32'(wr_en), 1);
                check("hold_addr", 32'(wr_addr), 32'(prev_addr));
                check("hold_data", 32'(wr_data), 32'(prev_data));
            end
            prev_stall = 1'b0;
            if (wr_en) begin
                if (first_cyc < 0) first_cyc = cyc;
                check("addr_range", 32'(wr_addr < 13'd6144), 1);
                if (wr_ready) begin
                    if (idx < n) check("wr_addr", 32'(wr_addr), exp_q[idx]);
                    else         check("extra_write", idx + 1, n);
                    check("wr_data", 32'(wr_data), 32'(col));
                    idx++;
                    last_hs = cyc;
                end else begin
                    prev_stall = 1'b1;
                    prev_addr  = wr_addr;
                    prev_data  = wr_data;
                end
            end
            if (done) begin
                done_cyc = cyc;
                check("done_no_wr", 32'(wr_en), 0);
                check("done_busy", 32'(busy), 1);
                check("done_ready", 32'(cmd_ready), 0);
            end
        end
        cmd_valid = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
        check("write_count", idx, n);
        if (n > 0) begin
            check("first_latency", first_cyc, 2);
            check("done_latency", done_cyc, last_hs + 1);
        end else begin
            check("empty_done_latency", done_cyc, 2);
            check("empty_no_write", first_cyc, -1);
        end
        if (mode == 0) check("throughput", done_cyc, n + 2);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("idle_ready", 32'(cmd_ready), 1);
        check("idle_busy", 32'(busy), 0);
        $display("cmd x0=%0d y0=%0d w=%0d h=%0d outl=%0d mode=%0d poke=%0d: %0d/%0d writes",
                 x0, y0, w, h, outl, mode, poke, idx, n);
    endtask

    task automatic reset_mid();
        int hs;
        hs = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_x0 = 7'd0; cmd_y0 = 7'd0; cmd_w = 7'd127; cmd_h = 7'd127;
        cmd_color = 16'h07E0; cmd_outline = 1'b0; wr_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 400 && hs < 100; c++) begin
            @(negedge clk);
            if (wr_en) hs++;
        end
        check("reset_mid_reached", hs, 100);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_wr_en", 32'(wr_en), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ready", 32'(cmd_ready), 1);
        check("rst_mid_done", 32'(done), 0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_mid_quiet", 32'(wr_en | busy), 0);
        end
        $display("reset mid-command after %0d writes", hs);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; cmd_outline = 1'b0; wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        $display("reset state checked");
        reset = 1'b0;

        run_cmd(10, 5, 3, 2, 16'hF800, 1'b0, 0, 1'b0);
        run_cmd(94, 62, 5, 5, 16'h001F, 1'b0, 0, 1'b0);
        run_cmd(100, 62, 5, 5, 16'h001F, 1'b0, 0, 1'b0);
        run_cmd(0, 0, 4, 4, 16'hFFFF, 1'b1, 0, 1'b0);
        run_cmd(0, 0, 1, 3, 16'h1234, 1'b1, 0, 1'b0);
        run_cmd(10, 5, 3, 2, 16'hF800, 1'b0, 1, 1'b0);
        run_cmd(10, 5, 3, 2, 16'hF800, 1'b0, 0, 1'b1);
        run_cmd(90, 60, 20, 10, 16'hABCD, 1'b1, 2, 1'b0);
        run_cmd(5, 5, 0, 7, 16'h5555, 1'b0, 0, 1'b0);
        run_cmd(0, 0, 127, 127, 16'h0F0F, 1'b0, 0, 1'b0);
        reset_mid();

        for (int i = 0; i < 30; i++) begin
            int x0, y0, w, h;
            x0 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 95);
            y0 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 63);
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 30);
            h  = $urandom_range(0, 16);
            run_cmd(x0, y0, w, h, 16'($urandom), 1'($urandom), $urandom_range(0, 2),
                    1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
